// File: rtl/cda_seq_mul.sv
// ---------------------------------------------------------------------------
// cda_seq_mul
//   Multi-cycle A_W x B_W multiplier built around one shared 8x4 core.
//   Each RUN cycle feeds one multiplicand byte and one multiplier nibble to
//   the core, shifts the 12-bit core result into place and adds it into a
//   full-carry accumulator. The default core is carry-disregard (carry-less,
//   GF(2)) so the product is approximate.
//
//   Build option (macro): CDA_SEQ_EXACT_EN
//     defined   -> the core computes the exact byte*nibble product, p = a*b
//     undefined -> carry-less core, approximate p (default)
//   Timing and handshakes are identical in both builds.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk edge where valid && ready are both 1.
//   The producer holds a/b stable while in_valid=1 and in_ready=0. The block
//   holds p stable and out_valid high until the consumer accepts (out_ready=1).
//   in_ready depends only on state, never combinationally on in_valid.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst_n      in   1        asynchronous active-low reset
//   in_valid   in   1        operand pair a,b is valid
//   in_ready   out  1        block can accept operands (IDLE only)
//   a          in   A_W      multiplicand
//   b          in   B_W      multiplier
//   flush      in   1        synchronous abort of the current operation
//   busy       out  1        operation in progress (RUN)
//   out_valid  out  1        p is valid (DONE)
//   out_ready  in   1        consumer accepts p
//   p          out  A_W+B_W  product (approximate unless exact build)
//   dbg_state  out  2        FSM state for observation: 0 IDLE, 1 RUN, 2 DONE
// ---------------------------------------------------------------------------
module cda_seq_mul #(
    parameter int A_W = 16,
    parameter int B_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               flush,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [A_W+B_W-1:0] p,
    output logic [1:0]         dbg_state
);

    localparam int NA    = A_W / 8;
    localparam int NB    = B_W / 4;
    localparam int STEPS = NA * NB;
    localparam int PW    = A_W + B_W;
    localparam int AI_W  = (NA > 1) ? $clog2(NA) : 1;
    localparam int BJ_W  = (NB > 1) ? $clog2(NB) : 1;
    localparam int SH_W  = $clog2(PW) + 1;

    // Elaboration-time parameter sanity checks.
    if ((A_W % 8) != 0 || A_W < 8) begin : g_bad_a_w
        $error("cda_seq_mul: A_W must be a non-zero multiple of 8");
    end
    if ((B_W % 4) != 0 || B_W < 4) begin : g_bad_b_w
        $error("cda_seq_mul: B_W must be a non-zero multiple of 4");
    end
    if (STEPS < 1) begin : g_bad_steps
        $error("cda_seq_mul: STEPS must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [A_W-1:0]    r_a_q;
    logic [B_W-1:0]    r_b_q;
    logic [PW-1:0]     r_acc;
    logic [PW-1:0]     r_p;
    // Step k is tracked as the pair (i, j) = (k / NB, k % NB) so no divider
    // is needed for non-power-of-two NB.
    logic [AI_W-1:0]   r_ai;
    logic [BJ_W-1:0]   r_bj;

    logic              w_accept;
    logic              w_step;
    logic              w_last;
    logic [7:0]        w_a_byte;
    logic [3:0]        w_b_nib;
    logic [11:0]       w_core;
    logic [SH_W-1:0]   w_shamt;
    logic [PW-1:0]     w_term;
    logic [PW-1:0]     w_acc_sum;

    // ------------------------------------------------------------------
    // Operand slice selection for the current step.
    // ------------------------------------------------------------------
    always_comb begin
        w_a_byte = '0;
        for (int n = 0; n < NA; n++) begin
            if (r_ai == AI_W'(n)) begin
                w_a_byte = r_a_q[8*n +: 8];
            end
        end
    end

    always_comb begin
        w_b_nib = '0;
        for (int n = 0; n < NB; n++) begin
            if (r_bj == BJ_W'(n)) begin
                w_b_nib = r_b_q[4*n +: 4];
            end
        end
    end

    // ------------------------------------------------------------------
    // 8x4 core.
    // ------------------------------------------------------------------
`ifdef CDA_SEQ_EXACT_EN
    // 255 * 15 = 3825 fits in 12 bits, so no truncation occurs.
    always_comb begin
        w_core = 12'(w_a_byte) * 12'(w_b_nib);
    end
`else
    // Carry-disregard: partial products are XORed, never added, so no carry
    // propagates. The top partial product reaches bit 10 at most; bit 11 is 0.
    always_comb begin
        w_core = '0;
        for (int n = 0; n < 4; n++) begin
            if (w_b_nib[n]) begin
                w_core = w_core ^ (12'(w_a_byte) << n);
            end
        end
    end
`endif

    // Weight of the partial result is 2^(8i + 4j).
    assign w_shamt   = SH_W'({r_ai, 3'b000}) + SH_W'({r_bj, 2'b00});
    assign w_term    = PW'(w_core) << w_shamt;
    // Full-carry accumulation; the worst-case sum fits in PW bits.
    assign w_acc_sum = r_acc + w_term;

    assign w_last = (r_ai == AI_W'(NA - 1)) && (r_bj == BJ_W'(NB - 1));

    // ------------------------------------------------------------------
    // FSM: state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes. flush wins over everything,
    // including acceptance in IDLE and the final step in RUN.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!flush && in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from state only.
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_q <= '0;
            r_b_q <= '0;
            r_acc <= '0;
            r_p   <= '0;
            r_ai  <= '0;
            r_bj  <= '0;
        end else if (w_accept) begin
            r_a_q <= a;
            r_b_q <= b;
            r_acc <= '0;
            r_ai  <= '0;
            r_bj  <= '0;
        end else if (w_step) begin
            r_acc <= w_acc_sum;
            if (w_last) begin
                // p only changes here, so it is stable throughout DONE and
                // keeps its old value when an operation is flushed.
                r_p  <= w_acc_sum;
                r_ai <= '0;
                r_bj <= '0;
            end else if (r_bj == BJ_W'(NB - 1)) begin
                r_bj <= '0;
                r_ai <= r_ai + 1'b1;
            end else begin
                r_bj <= r_bj + 1'b1;
            end
        end
    end

    assign p         = r_p;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cda_seq_mul.sv
module tb_cda_seq_mul;

    localparam int A_W   = 16;
    localparam int B_W   = 16;
    localparam int PW    = 32;
    localparam int STEPS = 8;

`ifdef CDA_SEQ_EXACT_EN
    localparam logic [31:0] L_FF_F   = 32'h0000_0EF1;
    localparam logic [31:0] L_FFFF   = 32'hFFFE_0001;
    localparam logic [31:0] L_3_3    = 32'h0000_0009;
`else
    localparam logic [31:0] L_FF_F   = 32'h0000_0505;
    localparam logic [31:0] L_FFFF   = 32'h55FF_FF55;
    localparam logic [31:0] L_3_3    = 32'h0000_0005;
`endif

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [A_W-1:0]  a = '0;
    logic [B_W-1:0]  b = '0;
    logic            flush = 1'b0;
    logic            busy;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [PW-1:0]   p;
    logic [1:0]      dbg_state;

    always #5 clk = ~clk;

    cda_seq_mul #(.A_W(A_W), .B_W(B_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .dbg_state (dbg_state)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    // Product defined as a sum over byte/nibble pairs of the carry-less
    // byte x nibble product, weighted by 2^(8i+4j); exact build uses a*b.
    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
`ifdef CDA_SEQ_EXACT_EN
        return 32'(x) * 32'(y);
`else
        logic [31:0] s;
        logic [31:0] cl;
        logic [7:0]  xb;
        logic [3:0]  yn;
        s = 0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 4; j++) begin
                xb = 8'(x >> (8 * i));
                yn = 4'(y >> (4 * j));
                cl = 0;
                for (int n = 0; n < 4; n++) begin
                    if (yn[n]) cl = cl ^ (32'(xb) << n);
                end
                s = s + (cl << (8 * i + 4 * j));
            end
        end
        return s;
`endif
    endfunction

    // ---------------- cycle-level behavioural model ----------------
    // m_mode: 0 waiting for operands, 1 computing, 2 result offered.
    int          m_mode = 0;
    int          m_cnt  = 0;
    logic [31:0] m_res  = '0;
    logic [31:0] m_p    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0;
            m_cnt  <= 0;
            m_res  <= '0;
            m_p    <= '0;
        end else begin
            case (m_mode)
                0: if (!flush && in_valid) begin
                    m_res  <= ref_mul(a, b);
                    m_cnt  <= STEPS;
                    m_mode <= 1;
                end
                1: if (flush) begin
                    m_mode <= 0;
                end else if (m_cnt == 1) begin
                    m_p    <= m_res;
                    m_mode <= 2;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                default: if (flush || out_ready) m_mode <= 0;
            endcase
        end
    end

    // ---------------- scoreboard / compare process ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("cyc_in_ready",  32'(in_ready),  32'(m_mode == 0));
            check("cyc_busy",      32'(busy),      32'(m_mode == 1));
            check("cyc_out_valid", 32'(out_valid), 32'(m_mode == 2));
            check("cyc_p",         p,              m_p);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end just after a falling edge.
    task automatic wait_out(input string nm, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ok  = 1'b1;
                lat = c + 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: out_valid not seen within 40 cycles, expected it", nm);
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] exp_lit, input int stall);
        bit ok;
        int lat;
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = (stall == 0);
        @(negedge clk);
        in_valid = 1'b0;
        check({nm, "_busy"}, 32'(busy), 32'd1);
        wait_out(nm, ok, lat);
        if (ok) begin
            check({nm, "_latency"}, 32'(lat), 32'(STEPS));
            check({nm, "_p"}, p, exp_lit);
            for (int s = 0; s < stall; s++) begin
                @(negedge clk);
                check({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                check({nm, "_hold_p"}, p, exp_lit);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check({nm, "_idle_in_ready"}, 32'(in_ready), 32'd1);
            check({nm, "_idle_out_valid"}, 32'(out_valid), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int lat;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p",         p,              32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Pin the reference model to hand-computed values.
        check("pin_ff_f",   ref_mul(16'h00FF, 16'h000F), L_FF_F);
        check("pin_ffff",   ref_mul(16'hFFFF, 16'hFFFF), L_FFFF);
        check("pin_1_3",    ref_mul(16'h0001, 16'h0003), 32'h3);
        check("pin_3_3",    ref_mul(16'h0003, 16'h0003), L_3_3);
        check("pin_100_30", ref_mul(16'h0100, 16'h0030), 32'h3000);

        // Main function, back-to-back operations, zero operands.
        run_op("ff_f",    16'h00FF, 16'h000F, L_FF_F, 0);
        run_op("ffff",    16'hFFFF, 16'hFFFF, L_FFFF, 0);
        run_op("a_zero",  16'h0000, 16'hFFFF, 32'h0,  0);
        run_op("b_zero",  16'hFFFF, 16'h0000, 32'h0,  0);

        // Backpressure: consumer stalls for 5 cycles.
        run_op("bp",      16'h0100, 16'h0030, 32'h3000, 5);

        // flush at RUN step 3: accepted at edge T, flush sampled at edge T+4.
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_run_in_ready",  32'(in_ready),  32'd1);
        check("flush_run_busy",      32'(busy),      32'd0);
        check("flush_run_out_valid", 32'(out_valid), 32'd0);
        check("flush_run_p_kept",    p,              32'h3000);
        repeat (10) begin
            @(negedge clk);
            check("flush_run_no_valid", 32'(out_valid), 32'd0);
        end
        run_op("after_flush", 16'h0001, 16'h0003, 32'h3, 0);

        // in_valid held high with new operands during RUN: must be ignored.
        in_valid = 1'b1;
        a = 16'h00FF;
        b = 16'h000F;
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        wait_out("held", ok, lat);
        in_valid = 1'b0;
        if (ok) begin
            check("held_p", p, L_FF_F);
        end
        @(negedge clk);
        check("held_idle", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("held_no_second", 32'(busy), 32'd0);

        // flush in IDLE takes priority over in_valid.
        in_valid = 1'b1;
        flush    = 1'b1;
        a = 16'h1234;
        b = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_idle_in_ready", 32'(in_ready), 32'd1);
        check("flush_idle_busy",     32'(busy),     32'd0);

        // flush while the result is offered: valid drops, p is kept.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'h0003;
        b = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        wait_out("flush_done", ok, lat);
        if (ok) begin
            check("flush_done_p", p, L_3_3);
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            check("flush_done_out_valid", 32'(out_valid), 32'd0);
            check("flush_done_in_ready",  32'(in_ready),  32'd1);
            check("flush_done_p_kept",    p,              L_3_3);
        end
        out_ready = 1'b1;

        // Asynchronous reset in the middle of RUN.
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready",  32'(in_ready),  32'd1);
        check("arst_busy",      32'(busy),      32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_p",         p,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_rst", 16'h0001, 16'h0003, 32'h3, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
